fp_match_ctrl: RTL

Sequences one fingerprint comparison over the fp_store search port: the enrolled template RAM against the freshly captured test RAM.
- Scans all template rows at each vertical row offset in −MAX_SHIFT..+MAX_SHIFT.
- Per row, accumulates popcount(tmpl & test) as "right" and popcount(tmpl ^ test) as "false".
- Reports the best offset's scores and a match flag.
- Clocked in the search clock domain; replaces the ad-hoc scoring loop inside display, which then only shows max_right/max_false.

---
 rtl/fp_pkg.sv | 33 +++
 rtl/fp_row_score.sv | 53 +++++
 rtl/fp_match_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fp_pkg                                                          |
// | Purpose  : Shared FSM encodings and helpers for fingerprint matching.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package fp_pkg;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ISSUE = 3'd1;
    localparam logic [2:0] c_ST_DRAIN = 3'd2;
    localparam logic [2:0] c_ST_EVAL  = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    // Widest row the popcount helper accepts; narrower rows are zero-extended.
    localparam int c_POP_MAX_W = 1024;

    // Signed offset width able to hold -max_shift..+max_shift.
    function automatic int off_width(input int max_shift);
        return $clog2(2 * max_shift + 1) + 1;
    endfunction

    function automatic int unsigned popcount(input logic [c_POP_MAX_W-1:0] vec);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < c_POP_MAX_W; i++) begin
            cnt += 32'(vec[i]);
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_row_score.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fp_row_score                                                    |
// | Purpose  : Registered popcounts of AND / XOR for one template/test row.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fp_row_score
    import fp_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_valid,
    output logic [CNT_W-1:0]  o_pop_and,
    output logic [CNT_W-1:0]  o_pop_xor
);

    logic [c_POP_MAX_W-1:0] w_and_ext;
    logic [c_POP_MAX_W-1:0] w_xor_ext;
    logic                   r_valid;
    logic [CNT_W-1:0]       r_pop_and;
    logic [CNT_W-1:0]       r_pop_xor;

    always_comb begin
        w_and_ext               = '0;
        w_xor_ext               = '0;
        w_and_ext[DATA_W-1:0]   = i_a & i_b;
        w_xor_ext[DATA_W-1:0]   = i_a ^ i_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pop_and <= '0;
            r_pop_xor <= '0;
        end else begin
            r_valid   <= i_valid;
            r_pop_and <= CNT_W'(popcount(w_and_ext));
            r_pop_xor <= CNT_W'(popcount(w_xor_ext));
        end
    end

    assign o_valid   = r_valid;
    assign o_pop_and = r_pop_and;
    assign o_pop_xor = r_pop_xor;

endmodule
`default_nettype wire

// File: rtl/fp_match_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fp_match_ctrl                                                   |
// | Purpose  : Scans template vs test RAM over row offsets, reports best score.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fp_match_ctrl
    import fp_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int ROWS      = 256,
    parameter int DATA_W    = 256,
    parameter int MAX_SHIFT = 4,
    parameter int RD_LAT    = 1,
    parameter int SCALE     = 6,
    parameter int THR_R     = 50,
    parameter int THR_F     = 80
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            tmpl_valid,
    output logic                            tmpl_rd,
    output logic [ADDR_W-1:0]               tmpl_add,
    input  logic [DATA_W-1:0]               tmpl_data,
    output logic                            test_rd,
    output logic [ADDR_W-1:0]               test_add,
    input  logic [DATA_W-1:0]               test_data,
    output logic                            busy,
    output logic                            done,
    output logic [7:0]                      max_right,
    output logic [7:0]                      max_false,
    output logic [off_width(MAX_SHIFT)-1:0] best_off,
    output logic                            match
);

    localparam int c_OFF_W = off_width(MAX_SHIFT);
    localparam int c_CNT_W = $clog2(DATA_W) + 1;
    localparam int c_SUM_W = $clog2(DATA_W) + ADDR_W + 1;
    localparam int c_T_W   = ADDR_W + c_OFF_W + 1;

    localparam logic [c_OFF_W-1:0] c_OFF_MIN    = c_OFF_W'(-MAX_SHIFT);
    localparam logic [c_OFF_W-1:0] c_OFF_MAX    = c_OFF_W'(MAX_SHIFT);
    localparam logic [ADDR_W-1:0]  c_ROW_LAST   = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0]  c_DRAIN_LAST = ADDR_W'(RD_LAT);
    localparam logic [c_T_W-1:0]   c_ROWS_T     = c_T_W'(ROWS);
    localparam logic [c_SUM_W-1:0] c_SAT        = c_SUM_W'(255);

    logic [2:0]         r_state;
    logic [ADDR_W-1:0]  r_cnt;
    logic [c_OFF_W-1:0] r_off;
    logic [RD_LAT-1:0]  r_vpipe;
    logic [c_SUM_W-1:0] r_sum_and;
    logic [c_SUM_W-1:0] r_sum_xor;
    logic [7:0]         r_best_right;
    logic [7:0]         r_best_false;
    logic [c_OFF_W-1:0] r_best_off;
    logic [7:0]         r_max_right;
    logic [7:0]         r_max_false;
    logic [c_OFF_W-1:0] r_out_off;
    logic               r_match;

    logic [c_T_W-1:0]   w_t;
    logic               w_rd;
    logic               w_pop_vld;
    logic [c_CNT_W-1:0] w_pop_and;
    logic [c_CNT_W-1:0] w_pop_xor;
    logic [c_SUM_W-1:0] w_sh_and;
    logic [c_SUM_W-1:0] w_sh_xor;
    logic [7:0]         w_right;
    logic [7:0]         w_false;
    logic               w_take;
    logic [7:0]         w_nb_right;
    logic [7:0]         w_nb_false;
    logic [c_OFF_W-1:0] w_nb_off;
    logic               w_nb_match;
    logic               w_clr;

    // Test row = template row + signed offset; out-of-range rows skip the read.
    assign w_t  = c_T_W'(r_cnt) + {{(c_T_W - c_OFF_W){r_off[c_OFF_W-1]}}, r_off};
    assign w_rd = (r_state == c_ST_ISSUE) && !w_t[c_T_W-1] && (w_t < c_ROWS_T);

    assign tmpl_rd  = w_rd;
    assign test_rd  = w_rd;
    assign tmpl_add = w_rd ? r_cnt : '0;
    assign test_add = w_rd ? w_t[ADDR_W-1:0] : '0;
    assign busy     = (r_state == c_ST_ISSUE) || (r_state == c_ST_DRAIN) || (r_state == c_ST_EVAL);
    assign done     = (r_state == c_ST_DONE);

    assign max_right = r_max_right;
    assign max_false = r_max_false;
    assign best_off  = r_out_off;
    assign match     = r_match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= w_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
        end
    end

    fp_row_score #(
        .DATA_W (DATA_W),
        .CNT_W  (c_CNT_W)
    ) u_row_score (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (r_vpipe[RD_LAT-1]),
        .i_a       (tmpl_data),
        .i_b       (test_data),
        .o_valid   (w_pop_vld),
        .o_pop_and (w_pop_and),
        .o_pop_xor (w_pop_xor)
    );

    assign w_clr = ((r_state == c_ST_IDLE) && start && tmpl_valid) ||
                   ((r_state == c_ST_EVAL) && (r_off != c_OFF_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum_and <= '0;
            r_sum_xor <= '0;
        end else if (w_clr) begin
            r_sum_and <= '0;
            r_sum_xor <= '0;
        end else if (w_pop_vld) begin
            r_sum_and <= r_sum_and + c_SUM_W'(w_pop_and);
            r_sum_xor <= r_sum_xor + c_SUM_W'(w_pop_xor);
        end
    end

    assign w_sh_and = r_sum_and >> SCALE;
    assign w_sh_xor = r_sum_xor >> SCALE;
    assign w_right  = (w_sh_and > c_SAT) ? 8'hFF : w_sh_and[7:0];
    assign w_false  = (w_sh_xor > c_SAT) ? 8'hFF : w_sh_xor[7:0];

    // Strictly-greater update keeps the earliest (most negative) offset on ties.
    assign w_take     = (r_off == c_OFF_MIN) || (w_right > r_best_right);
    assign w_nb_right = w_take ? w_right : r_best_right;
    assign w_nb_false = w_take ? w_false : r_best_false;
    assign w_nb_off   = w_take ? r_off   : r_best_off;
    assign w_nb_match = (int'(w_nb_right) > THR_R) && (int'(w_nb_false) < THR_F);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_off        <= '0;
            r_best_right <= '0;
            r_best_false <= '0;
            r_best_off   <= '0;
            r_max_right  <= '0;
            r_max_false  <= '0;
            r_out_off    <= '0;
            r_match      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        if (tmpl_valid) begin
                            r_state <= c_ST_ISSUE;
                            r_off   <= c_OFF_MIN;
                            r_cnt   <= '0;
                        end else begin
                            r_state     <= c_ST_DONE;
                            r_max_right <= '0;
                            r_max_false <= '0;
                            r_out_off   <= '0;
                            r_match     <= 1'b0;
                        end
                    end
                end
                c_ST_ISSUE: begin
                    if (r_cnt == c_ROW_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                c_ST_DRAIN: begin
                    if (r_cnt == c_DRAIN_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_EVAL;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                c_ST_EVAL: begin
                    r_best_right <= w_nb_right;
                    r_best_false <= w_nb_false;
                    r_best_off   <= w_nb_off;
                    if (r_off == c_OFF_MAX) begin
                        r_state     <= c_ST_DONE;
                        r_max_right <= w_nb_right;
                        r_max_false <= w_nb_false;
                        r_out_off   <= w_nb_off;
                        r_match     <= w_nb_match;
                    end else begin
                        r_off   <= r_off + c_OFF_W'(1);
                        r_state <= c_ST_ISSUE;
                    end
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
